led_blink_arbiter: RTL and testbench

Shares one blink timing engine among four requesters and drives four board LEDs. A requester raises its REQ line; the block grants the LEDs to one requester at a time and blinks that requester's LED a fixed number of times. It then pulses ACK and moves to the next request. It sits between status logic (fault flags, key events) and the LED pins, so every status source blinks at the same rate without each carrying its own 27-bit timer.

---
 rtl/led_blink_arbiter.sv | 148 ++++++++++++++
 tb/tb_led_blink_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/led_blink_arbiter.sv
// Four-requester LED blink arbiter that shares one ms tick and phase timer across all requesters.
// Build option: define FIXED_PRIO_EN for fixed priority (REQ[0] highest) instead of round-robin.
module led_blink_arbiter #(
  parameter int TICK_DIV = 50_000,
  parameter int HALF_MS  = 500,
  parameter int BLINKS   = 3
) (
  input  logic       CLK_50M,
  input  logic       RST_N,
  input  logic [3:0] REQ,
  output logic [3:0] GRANT,
  output logic [3:0] ACK,
  output logic       BUSY,
  output logic [3:0] LED,
  output logic [1:0] state_dbg
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MW = (HALF_MS > 1) ? $clog2(HALF_MS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      owner;
  logic [3:0]      owner_oh;
  logic [TW-1:0]   tick_cnt;
  logic [MW-1:0]   ms_cnt;
  logic [3:0]      blink_cnt;
  logic [3:0]      blink_inc;
  logic            tick;
  logic            phase_end;
  logic            abort;
  logic [1:0]      win;
  logic            found;

`ifndef FIXED_PRIO_EN
  logic [1:0]      rr_ptr;
`endif

  assign owner_oh  = 4'b0001 << owner;
  assign tick      = (tick_cnt == TW'(TICK_DIV - 1));
  assign phase_end = tick && (ms_cnt == MW'(HALF_MS - 1));
  assign blink_inc = blink_cnt + 4'd1;
  // Only the current owner's line can end its service early.
  assign abort     = ((state == S_ON) || (state == S_OFF)) && !REQ[owner];

  // Winner selection; only consumed in IDLE.
  always_comb begin
    win   = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
`ifdef FIXED_PRIO_EN
      if (!found && REQ[i]) begin
        win   = 2'(i);
        found = 1'b1;
      end
`else
      if (!found && REQ[rr_ptr + 2'(i)]) begin
        win   = rr_ptr + 2'(i);
        found = 1'b1;
      end
`endif
    end
  end

  // State register and timing datapath.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      owner     <= 2'd0;
      tick_cnt  <= '0;
      ms_cnt    <= '0;
      blink_cnt <= 4'd0;
`ifndef FIXED_PRIO_EN
      rr_ptr    <= 2'd0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          tick_cnt  <= '0;
          ms_cnt    <= '0;
          blink_cnt <= 4'd0;
          if (found) begin
            owner  <= win;
`ifndef FIXED_PRIO_EN
            rr_ptr <= win + 2'd1;
`endif
          end
        end
        S_ON, S_OFF: begin
          if (abort || phase_end) begin
            tick_cnt <= '0;
            ms_cnt   <= '0;
            if ((state == S_OFF) && phase_end && !abort)
              blink_cnt <= blink_inc;
          end else if (tick) begin
            tick_cnt <= '0;
            ms_cnt   <= ms_cnt + MW'(1);
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        default: begin
          tick_cnt <= '0;
          ms_cnt   <= '0;
        end
      endcase
    end
  end

  // Next-state logic; abort takes precedence over a phase boundary.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (found) state_nxt = S_ON;
      S_ON: begin
        if (abort)          state_nxt = S_IDLE;
        else if (phase_end) state_nxt = S_OFF;
      end
      S_OFF: begin
        if (abort)          state_nxt = S_IDLE;
        else if (phase_end) state_nxt = (blink_inc == 4'(BLINKS)) ? S_DONE : S_ON;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode registered state only, so REQ never reaches a pin combinationally.
  always_comb begin
    GRANT     = 4'd0;
    ACK       = 4'd0;
    LED       = 4'd0;
    BUSY      = (state != S_IDLE);
    state_dbg = state;
    if (state != S_IDLE) GRANT = owner_oh;
    if (state == S_ON)   LED   = owner_oh;
    if (state == S_DONE) ACK   = owner_oh;
  end

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Directed bench for led_blink_arbiter with TICK_DIV=4, HALF_MS=2, BLINKS=2 (8-cycle phases).
module tb_led_blink_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [3:0] ack;
  logic       busy;
  logic [3:0] led;
  logic [1:0] state_dbg;

  int n_total = 0;
  int n_bad   = 0;

  led_blink_arbiter #(.TICK_DIV(4), .HALF_MS(2), .BLINKS(2)) dut (
    .CLK_50M   (clk),
    .RST_N     (rst_n),
    .REQ       (req),
    .GRANT     (grant),
    .ACK       (ack),
    .BUSY      (busy),
    .LED       (led),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((grant == 4'd0) && (n < 100));
    check("grant_seen", 32'(grant != 4'd0), 1);
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((ack == 4'd0) && (n < 100));
    check("ack_seen", 32'(ack != 4'd0), 1);
  endtask

  initial begin
    int n;
    int lit;
    int ack_hi;
    logic [3:0] exp_led;

    rst_n = 1'b0;
    req   = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_ack", ack, 0);
    check("rst_led", led, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, 0);

    // 1: reset in the middle of an ON phase
    rst_n = 1'b1;
    req   = 4'b0001;
    repeat (3) @(negedge clk);
    check("t1_led_pre", led, 4'b0001);
    rst_n = 1'b0;
    #1;
    check("t1_led_async", led, 0);
    check("t1_grant_async", grant, 0);
    check("t1_ack_async", ack, 0);
    check("t1_busy_async", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    lit = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (led == 4'b0001) lit++;
    end
    check("t1_on_cycles", lit, 8);
    @(negedge clk);
    check("t1_off_after", led, 0);
    req = 4'd0;
    @(negedge clk);
    check("t1_idle_busy", busy, 0);

    // 2: single request, full service
    do_reset();
    req = 4'b0100;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      exp_led = ((c <= 8) || ((c >= 17) && (c <= 24))) ? 4'b0100 : 4'b0000;
      check("t2_led", led, exp_led);
      check("t2_ack", ack, (c == 33) ? 4'b0100 : 4'b0000);
      check("t2_busy", busy, (c <= 33) ? 1 : 0);
      check("t2_grant", grant, (c <= 33) ? 4'b0100 : 4'b0000);
      if (c == 33) req = 4'd0;
    end

`ifdef FIXED_PRIO_EN
    // 4: fixed priority, requester 3 starves
    do_reset();
    req = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      wait_grant(n);
      check("t4_grant", grant, 4'b0001);
      wait_ack(n);
      check("t4_ack", ack, 4'b0001);
      req[0] = 1'b0;
      @(negedge clk);
      check("t4_idle", grant, 0);
      req[0] = 1'b1;
    end
    req = 4'd0;
    repeat (3) @(negedge clk);
`else
    // 3: round-robin fairness
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_grant(n);
      check("t3_order", grant, 4'b0001 << k);
      check("t3_gap", n, (k == 0) ? 1 : 2);
      wait_ack(n);
      check("t3_ack", ack, 4'b0001 << k);
      check("t3_ack_led", led, 0);
      check("t3_service_len", n, 32);
      req[k] = 1'b0;
    end
    @(negedge clk);
    check("t3_end_idle", busy, 0);
`endif

    // 5: abort during the second ON phase
    do_reset();
    req = 4'b0010;
    for (int c = 1; c <= 21; c++) @(negedge clk);
    check("t5_led_pre", led, 4'b0010);
    req = 4'd0;
    @(negedge clk);
    check("t5_led", led, 0);
    check("t5_grant", grant, 0);
    check("t5_ack", ack, 0);
    check("t5_state", state_dbg, 0);
    check("t5_busy", busy, 0);
    ack_hi = 0;
    repeat (5) begin
      @(negedge clk);
      if (ack != 4'd0) ack_hi++;
    end
    check("t5_no_ack", ack_hi, 0);

    // 6: new request arrives in the DONE cycle of another
    do_reset();
    req = 4'b0010;
    wait_grant(n);
    check("t6_grant1", grant, 4'b0010);
    wait_ack(n);
    check("t6_ack1", ack, 4'b0010);
    req = 4'b0100;
    @(negedge clk);
    check("t6_idle_grant", grant, 0);
    check("t6_idle_ack", ack, 0);
    @(negedge clk);
    check("t6_grant2", grant, 4'b0100);
    check("t6_led2", led, 4'b0100);
    wait_ack(n);
    check("t6_ack2", ack, 4'b0100);
    check("t6_ack2_delay", n, 32);
    req = 4'd0;
    @(negedge clk);
    check("t6_ack_pulse", ack, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
